alu_frame_loader: RTL and testbench

// - Front-end stage for the 2-bit-opcode, 8-bit combinational ALU.
// - Assembles a 3-byte command frame from a valid/ready byte stream: header (op), operand a, operand b.
// - Drives registered op/a/b into the ALU, captures its result one cycle later, and returns it on a valid/ready result port.
// - One frame in flight; no overlap between input collection and result return.
//

---
 rtl/alu_frame_loader.sv | 135 +++++++++++++
 tb/tb_alu_frame_loader.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/alu_frame_loader.sv
// Front-end loader for the 2-bit-opcode combinational ALU.
// Collects a header/a/b frame from a byte stream, drives registered operands
// into the ALU, captures its result one cycle later and presents it on a
// valid/ready result port. Only one frame is in flight at a time.
module alu_frame_loader #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          CHECK_HDR = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [1:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] res_data,
  output logic [1:0]       res_op,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             hdr_err,
  output logic             busy
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] GET_A = 3'd1;
  localparam logic [2:0] GET_B = 3'd2;
  localparam logic [2:0] EXEC  = 3'd3;
  localparam logic [2:0] OUT   = 3'd4;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       in_fire;
  logic       res_fire;
  logic       hdr_bad;
  logic       hdr_err_nxt;
  logic       ld_op;
  logic       ld_a;
  logic       ld_b;
  logic       ld_res;

  // Stream accepts bytes only while a frame is being collected.
  assign in_ready = (state == IDLE) || (state == GET_A) || (state == GET_B);
  assign in_fire  = in_valid && in_ready;
  assign res_fire = res_valid && res_ready;
  assign hdr_bad  = CHECK_HDR && (in_data[WIDTH-1:2] != '0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and load-enable decode.
  always_comb begin
    state_nxt   = state;
    hdr_err_nxt = 1'b0;
    ld_op       = 1'b0;
    ld_a        = 1'b0;
    ld_b        = 1'b0;
    ld_res      = 1'b0;
    case (state)
      IDLE: begin
        if (in_fire) begin
          if (hdr_bad) begin
            hdr_err_nxt = 1'b1;
          end else begin
            ld_op     = 1'b1;
            state_nxt = GET_A;
          end
        end
      end
      GET_A: begin
        if (in_fire) begin
          ld_a      = 1'b1;
          state_nxt = GET_B;
        end
      end
      GET_B: begin
        if (in_fire) begin
          ld_b      = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        ld_res    = 1'b1;
        state_nxt = OUT;
      end
      OUT: begin
        if (res_fire) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand, result and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_op    <= 2'b00;
      alu_a     <= '0;
      alu_b     <= '0;
      res_data  <= '0;
      res_op    <= 2'b00;
      res_valid <= 1'b0;
      hdr_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      res_valid <= (state_nxt == OUT);
      busy      <= (state_nxt != IDLE);
      hdr_err   <= hdr_err_nxt;
      if (ld_op) begin
        alu_op <= in_data[1:0];
      end
      if (ld_a) begin
        alu_a <= in_data;
      end
      if (ld_b) begin
        alu_b <= in_data;
      end
      if (ld_res) begin
        res_data <= alu_out;
        res_op   <= alu_op;
      end
    end
  end

endmodule

// File: tb/tb_alu_frame_loader.sv
// Directed bench for alu_frame_loader with a behavioural ALU attached.
module tb_alu_frame_loader;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] res_data;
  logic [1:0]       res_op;
  logic             res_valid;
  logic             res_ready;
  logic             hdr_err;
  logic             busy;

  int checks;
  int errors;

  alu_frame_loader #(.WIDTH(WIDTH), .CHECK_HDR(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_op   (alu_op),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_out  (alu_out),
    .res_data (res_data),
    .res_op   (res_op),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .hdr_err  (hdr_err),
    .busy     (busy)
  );

  // Combinational ALU the loader feeds.
  always_comb begin
    case (alu_op)
      2'b00:   alu_out = alu_a + alu_b;
      2'b01:   alu_out = alu_a - alu_b;
      2'b10:   alu_out = alu_a & alu_b;
      default: alu_out = alu_a | alu_b;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time limit.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_alu_op"},   32'(alu_op),    32'h0);
    check({tag, "_alu_a"},    32'(alu_a),     32'h0);
    check({tag, "_alu_b"},    32'(alu_b),     32'h0);
    check({tag, "_res_data"}, 32'(res_data),  32'h0);
    check({tag, "_res_op"},   32'(res_op),    32'h0);
    check({tag, "_res_valid"},32'(res_valid), 32'h0);
    check({tag, "_hdr_err"},  32'(hdr_err),   32'h0);
    check({tag, "_busy"},     32'(busy),      32'h0);
    check({tag, "_in_ready"}, 32'(in_ready),  32'h1);
  endtask

  // Present one byte and return just after the edge that accepts it.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("send_timeout", 32'(n), 32'h0);
    tick();
    in_valid = 1'b0;
  endtask

  // Full frame with optional gap before b and result backpressure (hold cycles).
  task automatic run_frame(input string tag, input logic [7:0] op, input logic [7:0] a,
                           input logic [7:0] b, input int gap, input int hold,
                           input logic [7:0] exp);
    res_ready = (hold == 0);
    send_byte(op);
    send_byte(a);
    for (int i = 0; i < gap; i++) begin
      tick();
      check({tag, "_gap_busy"},  32'(busy),     32'h1);
      check({tag, "_gap_rdy"},   32'(in_ready), 32'h1);
      check({tag, "_gap_alu_a"}, 32'(alu_a),    32'(a));
    end
    send_byte(b);
    check({tag, "_exec_valid"}, 32'(res_valid), 32'h0);
    check({tag, "_exec_rdy"},   32'(in_ready),  32'h0);
    tick();
    check({tag, "_valid"},    32'(res_valid), 32'h1);
    check({tag, "_data"},     32'(res_data),  32'(exp));
    check({tag, "_op"},       32'(res_op),    32'(op[1:0]));
    check({tag, "_out_rdy"},  32'(in_ready),  32'h0);
    for (int i = 1; i < hold; i++) begin
      tick();
      check({tag, "_hold_valid"}, 32'(res_valid), 32'h1);
      check({tag, "_hold_data"},  32'(res_data),  32'(exp));
      check({tag, "_hold_rdy"},   32'(in_ready),  32'h0);
    end
    res_ready = 1'b1;
    tick();
    check({tag, "_done_valid"}, 32'(res_valid), 32'h0);
    check({tag, "_done_busy"},  32'(busy),      32'h0);
    check({tag, "_done_rdy"},   32'(in_ready),  32'h1);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    res_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_reset_state("reset");

    run_frame("add", 8'h00, 8'h05, 8'h03, 0, 0, 8'h08);
    check("add_alu_a", 32'(alu_a), 32'h05);
    check("add_alu_b", 32'(alu_b), 32'h03);

    run_frame("sub", 8'h01, 8'h03, 8'h05, 0, 0, 8'hFE);
    run_frame("or",  8'h03, 8'hA0, 8'h0F, 0, 0, 8'hAF);

    run_frame("and_bp", 8'h02, 8'hF0, 8'h3C, 0, 4, 8'h30);

    send_byte(8'h84);
    check("hdr_err_pulse", 32'(hdr_err),  32'h1);
    check("hdr_err_idle",  32'(busy),     32'h0);
    check("hdr_err_op",    32'(alu_op),   32'h2);
    check("hdr_err_rdy",   32'(in_ready), 32'h1);
    tick();
    check("hdr_err_clear", 32'(hdr_err),  32'h0);
    run_frame("after_hdr", 8'h00, 8'h01, 8'h01, 0, 0, 8'h02);

    run_frame("gap", 8'h00, 8'h10, 8'h20, 3, 0, 8'h30);

    // Reset while collecting b.
    send_byte(8'h00);
    send_byte(8'h11);
    check("pre_rst_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state("rst_getb");

    // Reset while a result is being held.
    res_ready = 1'b0;
    send_byte(8'h01);
    send_byte(8'h09);
    send_byte(8'h04);
    tick();
    check("pre_rst_out_valid", 32'(res_valid), 32'h1);
    check("pre_rst_out_data",  32'(res_data),  32'h05);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state("rst_out");

    run_frame("fresh", 8'h03, 8'h50, 8'h05, 0, 0, 8'h55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
